// File: rtl/interrupt_pkg.sv
// Shared encodings and defaults for the interrupt controller and its priority encoder.
package interrupt_pkg;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_VECTOR = 2'd1,
        IC_ISR    = 2'd2,
        IC_RETURN = 2'd3
    } ic_state_t;

    localparam int         DEF_NUM_IRQ    = 4;
    localparam int         DEF_ADDR_W     = 8;
    localparam logic [7:0] DEF_VEC_BASE   = 8'hF0;
    localparam int         DEF_VEC_STRIDE = 4;

    // An id field is never narrower than one bit, even for a single line.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Lowest-index-first priority encoder: index 0 is the most urgent request.
module irq_priority_encoder
    import interrupt_pkg::*;
#(
    parameter int N    = DEF_NUM_IRQ,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    output logic [ID_W-1:0] win,
    output logic            any
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        win = '0;
        any = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                win = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level prioritised interrupt controller; redirects the program sequencer
// to a vector on entry and back to the saved address on reti.
//
//  state     | meaning
//  IC_IDLE   | no ISR; waiting for an enabled pending request
//  IC_VECTOR | int_jmp asserted; request committed, waits out hold
//  IC_ISR    | handler running; waits for reti
//  IC_RETURN | ret_jmp asserted; waits out hold, then back to idle
module interrupt_controller
    import interrupt_pkg::*;
#(
    parameter int                NUM_IRQ    = DEF_NUM_IRQ,
    parameter int                ADDR_W     = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_BASE   = DEF_VEC_BASE,
    parameter int                VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_IRQ-1:0]           irq,
    input  logic                         mask_we,
    input  logic [NUM_IRQ-1:0]           mask_wdata,
    input  logic                         gie_set,
    input  logic                         gie_clr,
    input  logic                         reti,
    input  logic                         hold,
    input  logic [ADDR_W-1:0]            next_addr,
    output logic                         int_jmp,
    output logic                         ret_jmp,
    output logic [ADDR_W-1:0]            redirect_addr,
    output logic                         in_service,
    output logic [id_width(NUM_IRQ)-1:0] active_id,
    output logic [NUM_IRQ-1:0]           pending,
    output logic                         spurious_reti
);

    localparam int ID_W = id_width(NUM_IRQ);

    ic_state_t           state, next_state;
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  mask;
    logic                gie;
    logic [ADDR_W-1:0]   ret_reg;
    logic [NUM_IRQ-1:0]  rise;
    logic [NUM_IRQ-1:0]  req;
    logic [NUM_IRQ-1:0]  clr_vec;
    logic [ID_W-1:0]     win;
    logic                any;
    logic                take;
    logic                ack;
    logic [ADDR_W-1:0]   vec_addr;

    assign rise     = irq & ~irq_q;
    assign req      = pending & mask;
    assign ack      = (state == IC_VECTOR) && !hold;
    assign clr_vec  = ack ? (NUM_IRQ'(1) << active_id) : '0;
    // Vector arithmetic is done at ADDR_W so it wraps modulo the address space.
    assign vec_addr = VEC_BASE + ADDR_W'(active_id) * ADDR_W'(VEC_STRIDE);

    irq_priority_encoder #(
        .N    (NUM_IRQ),
        .ID_W (ID_W)
    ) u_prio (
        .req (req),
        .win (win),
        .any (any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IC_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        take       = 1'b0;
        case (state)
            IC_IDLE: begin
                if (gie && any && !hold) begin
                    take       = 1'b1;
                    next_state = IC_VECTOR;
                end
            end
            IC_VECTOR: begin
                if (!hold) next_state = IC_ISR;
            end
            IC_ISR: begin
                if (reti) next_state = IC_RETURN;
            end
            IC_RETURN: begin
                if (!hold) next_state = IC_IDLE;
            end
            default: next_state = IC_IDLE;
        endcase
    end

    // A rise in the acknowledge cycle re-sets the bit being cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q         <= '0;
            pending       <= '0;
            mask          <= '0;
            gie           <= 1'b0;
            ret_reg       <= '0;
            active_id     <= '0;
            spurious_reti <= 1'b0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~clr_vec) | rise;
            if (mask_we) mask <= mask_wdata;
            if (gie_clr) begin
                gie <= 1'b0;
            end else if (gie_set) begin
                gie <= 1'b1;
            end
            if (take) active_id <= win;
            if (ack) ret_reg <= next_addr;
            spurious_reti <= reti && ((state == IC_IDLE) || (state == IC_VECTOR));
        end
    end

    always_comb begin
        int_jmp       = (state == IC_VECTOR);
        ret_jmp       = (state == IC_RETURN);
        in_service    = (state == IC_ISR) || (state == IC_RETURN);
        redirect_addr = '0;
        if (state == IC_VECTOR) begin
            redirect_addr = vec_addr;
        end else if (state == IC_RETURN) begin
            redirect_addr = ret_reg;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: entry/return, priority, masking, hold,
// acknowledge/rise collision, spurious reti and reset during an ISR.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wdata;
    logic       gie_set;
    logic       gie_clr;
    logic       reti;
    logic       hold;
    logic [7:0] next_addr;
    logic       int_jmp;
    logic       ret_jmp;
    logic [7:0] redirect_addr;
    logic       in_service;
    logic [1:0] active_id;
    logic [3:0] pending;
    logic       spurious_reti;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_obs;
    logic [15:0] obs;

    // {int_jmp, ret_jmp, in_service, spurious_reti, pending, redirect_addr}
    assign obs = {int_jmp, ret_jmp, in_service, spurious_reti, pending, redirect_addr};

    always #5 clk = ~clk;

    interrupt_controller dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .irq           (irq),
        .mask_we       (mask_we),
        .mask_wdata    (mask_wdata),
        .gie_set       (gie_set),
        .gie_clr       (gie_clr),
        .reti          (reti),
        .hold          (hold),
        .next_addr     (next_addr),
        .int_jmp       (int_jmp),
        .ret_jmp       (ret_jmp),
        .redirect_addr (redirect_addr),
        .in_service    (in_service),
        .active_id     (active_id),
        .pending       (pending),
        .spurious_reti (spurious_reti)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; irq = '0; mask_we = 1'b0; mask_wdata = '0; gie_set = 1'b0;
        gie_clr = 1'b0; reti = 1'b0; hold = 1'b0; next_addr = '0;
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL reset_outputs: got %h want %h", obs, exp_obs); end
        n_cmp++;
        if (active_id !== 2'd0) begin n_err++; $display("FAIL reset_active_id: got %0d want 0", active_id); end
        cyc(); reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic();
        gie_set = 1'b1; mask_we = 1'b1; mask_wdata = 4'hF; next_addr = 8'h23;
        cyc();
        gie_set = 1'b0; mask_we = 1'b0; irq = 4'b0100;
        cyc();
        exp_obs = {4'b0000, 4'b0100, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL basic_pending: got %h want %h", obs, exp_obs); end
        irq = '0;
        cyc();
        exp_obs = {4'b1000, 4'b0100, 8'hF8}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL basic_vector: got %h want %h", obs, exp_obs); end
        n_cmp++;
        if (active_id !== 2'd2) begin n_err++; $display("FAIL basic_active_id: got %0d want 2", active_id); end
        cyc();
        exp_obs = {4'b0010, 4'b0000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL basic_isr: got %h want %h", obs, exp_obs); end
        reti = 1'b1; next_addr = 8'h99;
        cyc();
        exp_obs = {4'b0110, 4'b0000, 8'h23}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL basic_return: got %h want %h", obs, exp_obs); end
        reti = 1'b0;
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL basic_idle: got %h want %h", obs, exp_obs); end
    endtask

    task automatic test_priority();
        irq = 4'b1010;
        cyc();
        irq = '0;
        cyc();
        exp_obs = {4'b1000, 4'b1010, 8'hF4}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_first_vector: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b0010, 4'b1000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_isr: got %h want %h", obs, exp_obs); end
        reti = 1'b1;
        cyc();
        exp_obs = {4'b0110, 4'b1000, 8'h99}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_return: got %h want %h", obs, exp_obs); end
        reti = 1'b0;
        cyc();
        exp_obs = {4'b0000, 4'b1000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_idle_gap: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b1000, 4'b1000, 8'hFC}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_second_vector: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b0010, 4'b0000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL prio_second_isr: got %h want %h", obs, exp_obs); end
        reti = 1'b1;
        cyc();
        reti = 1'b0;
        cyc();
    endtask

    task automatic test_mask_gie();
        mask_we = 1'b1; mask_wdata = 4'b0000;
        cyc();
        mask_we = 1'b0; irq = 4'b0001;
        cyc();
        irq = '0;
        cyc();
        cyc();
        exp_obs = {4'b0000, 4'b0001, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL mask_blocks: got %h want %h", obs, exp_obs); end
        mask_we = 1'b1; mask_wdata = 4'b0001;
        cyc();
        mask_we = 1'b0;
        exp_obs = {4'b0000, 4'b0001, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL mask_write_cycle: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b1000, 4'b0001, 8'hF0}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL mask_unmask_vector: got %h want %h", obs, exp_obs); end
        cyc();
        reti = 1'b1;
        cyc();
        reti = 1'b0;
        cyc();
        gie_set = 1'b1; gie_clr = 1'b1;
        cyc();
        gie_set = 1'b0; gie_clr = 1'b0; irq = 4'b0001;
        cyc();
        irq = '0;
        cyc();
        cyc();
        exp_obs = {4'b0000, 4'b0001, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL gie_clr_wins: got %h want %h", obs, exp_obs); end
        gie_set = 1'b1;
        cyc();
        gie_set = 1'b0;
        cyc();
        exp_obs = {4'b1000, 4'b0001, 8'hF0}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL gie_set_vector: got %h want %h", obs, exp_obs); end
        cyc();
        reti = 1'b1;
        cyc();
        reti = 1'b0;
        cyc();
    endtask

    task automatic test_hold();
        mask_we = 1'b1; mask_wdata = 4'hF; irq = 4'b0010; next_addr = 8'h40;
        cyc();
        mask_we = 1'b0; irq = '0; hold = 1'b1;
        cyc();
        exp_obs = {4'b0000, 4'b0010, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_idle_blocks: got %h want %h", obs, exp_obs); end
        hold = 1'b0;
        cyc();
        exp_obs = {4'b1000, 4'b0010, 8'hF4}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_vector_entry: got %h want %h", obs, exp_obs); end
        for (int i = 0; i < 3; i++) begin
            hold = 1'b1; next_addr = 8'(8'h50 + i);
            cyc();
            exp_obs = {4'b1000, 4'b0010, 8'hF4}; n_cmp++;
            if (obs !== exp_obs) begin n_err++; $display("FAIL hold_vector_%0d: got %h want %h", i, obs, exp_obs); end
        end
        hold = 1'b0; next_addr = 8'h77;
        cyc();
        exp_obs = {4'b0010, 4'b0000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_isr: got %h want %h", obs, exp_obs); end
        next_addr = 8'h88; reti = 1'b1;
        cyc();
        reti = 1'b0; hold = 1'b1;
        exp_obs = {4'b0110, 4'b0000, 8'h77}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_ret_addr: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b0110, 4'b0000, 8'h77}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_return_stays: got %h want %h", obs, exp_obs); end
        hold = 1'b0;
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL hold_idle_after: got %h want %h", obs, exp_obs); end
    endtask

    task automatic test_boundary();
        irq = 4'b0100;
        cyc();
        irq = '0;
        cyc();
        exp_obs = {4'b1000, 4'b0100, 8'hF8}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL bnd_vector: got %h want %h", obs, exp_obs); end
        irq = 4'b0100;
        cyc();
        exp_obs = {4'b0010, 4'b0100, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL bnd_rise_wins_ack: got %h want %h", obs, exp_obs); end
        irq = '0; reti = 1'b1;
        cyc();
        reti = 1'b0;
        cyc();
        exp_obs = {4'b0000, 4'b0100, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL bnd_idle_gap: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = {4'b1000, 4'b0100, 8'hF8}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL bnd_reentry: got %h want %h", obs, exp_obs); end
        cyc();
        reti = 1'b1;
        cyc();
        reti = 1'b0;
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL bnd_drained: got %h want %h", obs, exp_obs); end
        reti = 1'b1;
        cyc();
        reti = 1'b0;
        exp_obs = {4'b0001, 4'b0000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL spurious_pulse: got %h want %h", obs, exp_obs); end
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL spurious_one_cycle: got %h want %h", obs, exp_obs); end
    endtask

    task automatic test_reset_mid_isr();
        irq = 4'b1000;
        cyc();
        irq = '0;
        cyc();
        cyc();
        exp_obs = {4'b0010, 4'b0000, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_in_isr: got %h want %h", obs, exp_obs); end
        irq = 4'b0001;
        cyc();
        irq = '0;
        exp_obs = {4'b0010, 4'b0001, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_pending_before: got %h want %h", obs, exp_obs); end
        reset_n = 1'b0;
        #1;
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_async_clear: got %h want %h", obs, exp_obs); end
        cyc();
        reset_n = 1'b1;
        cyc();
        exp_obs = 16'h0000; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_no_ret_jmp: got %h want %h", obs, exp_obs); end
        gie_set = 1'b1;
        cyc();
        gie_set = 1'b0; irq = 4'b0010;
        cyc();
        irq = '0;
        cyc();
        cyc();
        exp_obs = {4'b0000, 4'b0010, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_mask_cleared: got %h want %h", obs, exp_obs); end
        gie_clr = 1'b1; mask_we = 1'b1; mask_wdata = 4'hF;
        cyc();
        gie_clr = 1'b0; mask_we = 1'b0;
        cyc();
        cyc();
        exp_obs = {4'b0000, 4'b0010, 8'h00}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_gie_blocks: got %h want %h", obs, exp_obs); end
        gie_set = 1'b1;
        cyc();
        gie_set = 1'b0;
        cyc();
        exp_obs = {4'b1000, 4'b0010, 8'hF4}; n_cmp++;
        if (obs !== exp_obs) begin n_err++; $display("FAIL rst_after_gie_set: got %h want %h", obs, exp_obs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask_gie();
        test_hold();
        test_boundary();
        test_reset_mid_isr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Prioritised interrupt controller that redirects the program sequencer: latches interrupt edges, picks the highest-priority enabled request, and forces a one-cycle jump to its vector.
- Saves the return address and forces the jump back on reti.
- Sits beside program_sequencer. The sequencer gives int_jmp/ret_jmp priority below reset and above jmp, jmp_nz and pc+1.
- Single-level: no nesting.

Parameters:
NUM_IRQ, 4, number of interrupt lines; index 0 has highest priority
ADDR_W, 8, program memory address width
VEC_BASE, 8'hF0, address of the vector for irq 0
VEC_STRIDE, 4, address spacing between consecutive vectors

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
irq  in  NUM_IRQ  synchronous interrupt request lines; rising edge requests service
mask_we  in  1  write strobe for the mask register
mask_wdata  in  NUM_IRQ  new mask value; 1 = enabled
gie_set  in  1  pulse: set the global interrupt enable
gie_clr  in  1  pulse: clear the global interrupt enable
reti  in  1  pulse: the return-from-interrupt instruction is executing
hold  in  1  the sequencer is mid instruction-repeat; no redirect may occur
next_addr  in  ADDR_W  address the sequencer would fetch next if not redirected
int_jmp  out  1  force a jump to redirect_addr (interrupt entry)
ret_jmp  out  1  force a jump to redirect_addr (interrupt return)
redirect_addr  out  ADDR_W  vector address or saved return address
in_service  out  1  an ISR is executing
active_id  out  max(1,clog2(NUM_IRQ))  id of the request being or last serviced
pending  out  NUM_IRQ  latched, not-yet-serviced requests
spurious_reti  out  1  one-cycle pulse: reti received outside an ISR

Behaviour:
Reset (reset_n low, asynchronous):
- State goes to IDLE.
- pending, mask, gie, irq_q, ret_reg and active_id all go to 0.
- All outputs go to 0.
- Reset mid-ISR abandons the ISR; no ret_jmp is ever issued for it.

Edge detection and pending register:
- irq_q <= irq every cycle.
- rise = irq & ~irq_q.
- pending <= (pending & ~clr_vec) | rise. A new rise in the same cycle as an acknowledge of that bit wins (the bit stays set).
- Pending bits latch regardless of mask and gie.

Enables:
- mask <= mask_wdata when mask_we.
- gie_set and gie_clr in the same cycle: clear wins.

Request and priority:
- req = pending & mask.
- win = lowest index set in req.

FSM (state register; outputs decoded from state and registers):
- IDLE: if gie && |req && !hold, capture active_id <= win and go to VECTOR.
- VECTOR: drive int_jmp=1 and redirect_addr = VEC_BASE + active_id*VEC_STRIDE, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - If hold is 1, stay in VECTOR with outputs held and nothing captured.
  - Otherwise: ret_reg <= next_addr; clear pending[active_id]; go to ISR.
  - The request is committed once VECTOR is reached. A later mask or gie change does not cancel it.
- ISR: in_service=1. No new entry is taken. On reti go to RETURN.
- RETURN: drive ret_jmp=1 and redirect_addr=ret_reg; in_service stays 1.
  - If hold is 1, stay in RETURN.
  - Otherwise go to IDLE. At least one IDLE cycle follows before the next entry (no tail-chaining).

Other rules:
- reti in IDLE or VECTOR: one-cycle spurious_reti pulse; state unchanged.
- reti in RETURN: ignored.
- int_jmp and ret_jmp are never both 1.
- redirect_addr is 0 when neither jump is asserted.
- Latency, from rise sampled at edge k with gie=1, bit enabled, hold=0 and state IDLE:
  - pending visible after edge k.
  - VECTOR entered at edge k+1.
  - int_jmp high in cycle k+1..k+2.
  - ISR at edge k+2.

Decomposition:
- Shared package interrupt_pkg holds:
  - state encoding constants IC_IDLE, IC_VECTOR, IC_ISR, IC_RETURN (2 bits);
  - defaults NUM_IRQ=4, VEC_BASE=8'hF0, VEC_STRIDE=4.
- One sub-module, irq_priority_encoder: a parameterised lowest-index-first encoder producing win and any. Everything else stays in the top module.

Test Plan:
1. Basic entry and return (gie=1, mask=4'b1111, next_addr=8'h23): pulse irq[2]. Required: int_jmp for 1 cycle with redirect_addr=8'hF8, pending[2] cleared, in_service=1. Then reti with next_addr=8'h99: ret_jmp for 1 cycle with redirect_addr=8'h23, then IDLE.
2. Priority: rises on irq[3] and irq[1] in the same cycle. Required: vector 8'hF4 taken first. After reti and one IDLE cycle, vector 8'hFC is taken.
3. Masking and gie: mask=4'b0000, rise on irq[0]. Required: pending=4'b0001 and no int_jmp. Write mask=4'b0001: int_jmp follows with redirect_addr=8'hF0. Also check gie_set and gie_clr in the same cycle leaves gie=0.
4. Hold: hold=1 during VECTOR for 3 cycles. Required: int_jmp stays high and redirect_addr is stable. ret_reg captures the next_addr present on the first cycle with hold=0.
5. Boundary: a new rise on irq[2] in the same cycle its pending bit is acknowledged keeps pending[2]=1. A reti in IDLE pulses spurious_reti with no state change.
6. Reset mid-ISR: drop reset_n while in ISR. Required: immediately in_service=0, pending=0, mask=0, gie=0, no ret_jmp. After release, an irq is ignored until gie_set.
